i2c_arbitro: RTL

Two-port round-robin arbiter and sequencer for the I2C transaction generator (`i2c_generador`). It accepts transaction requests from two independent clients and serializes them onto the single master. For each transaction it drives the master's address, direction, write data and start strobe, then detects completion by counting SCL pulses. On completion it returns read data, an error flag and a done pulse to the client that owned the transaction.

---
 rtl/i2c_arb_pkg.sv | 23 ++
 rtl/i2c_scl_monitor.sv | 52 +++++
 rtl/i2c_arbitro.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_pkg.sv
// Shared types and default widths for the two-port I2C arbiter.
package i2c_arb_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 16;
  localparam int SCL_PULSES = 27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BUSY,
    ST_DRAIN,
    ST_DONE
  } arb_state_t;

  // One queued transaction: target address, direction and write payload.
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic                  rnw;
    logic [I2C_DATA_W-1:0] wdata;
  } i2c_op_t;

endpackage

// File: rtl/i2c_scl_monitor.sv
// SCL rising-edge counter plus BUSY-phase timeout counter.
// Both counters saturate and are held at zero while i_clear is high.
module i2c_scl_monitor
  import i2c_arb_pkg::*;
#(
  parameter int PULSES  = SCL_PULSES,
  parameter int TIMEOUT = 1023
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_scl,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_count_reached,
  output logic o_timeout_reached
);

  localparam int CNT_W = $clog2(PULSES + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  logic             r_scl_q;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             w_scl_rise;

  assign w_scl_rise        = i_scl & ~r_scl_q;
  assign o_count_reached   = (r_pulse_cnt == CNT_W'(PULSES));
  assign o_timeout_reached = (r_to_cnt == TO_W'(TIMEOUT));

  // Delay scl by one cycle for edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_scl_q <= 1'b0;
    else         r_scl_q <= i_scl;
  end

  // Count SCL rising edges while enabled, stopping at the target.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_pulse_cnt <= '0;
    else if (i_enable && w_scl_rise && !o_count_reached)
      r_pulse_cnt <= r_pulse_cnt + 1'b1;
  end

  // Count enabled cycles, stopping at the timeout limit.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_to_cnt <= '0;
    else if (i_enable && !o_timeout_reached)
      r_to_cnt <= r_to_cnt + 1'b1;
  end

endmodule

// File: rtl/i2c_arbitro.sv
// Two-port round-robin arbiter and sequencer in front of i2c_generador.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a pending port; winner's operands latched on exit
//   ST_START | start_stb high for START_LEN cycles, SCL/timeout cleared
//   ST_BUSY  | counting SCL edges, watching the timeout
//   ST_DRAIN | STOP_WAIT cycles for the stop condition; rdata latched on exit
//   ST_DONE  | one-cycle done pulse to the owner, pending cleared
module i2c_arbitro
  import i2c_arb_pkg::*;
#(
  parameter int START_LEN = 5,
  parameter int STOP_WAIT = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_p0_req,
  input  logic [I2C_ADDR_W-1:0] i_p0_addr,
  input  logic                  i_p0_rnw,
  input  logic [I2C_DATA_W-1:0] i_p0_wdata,
  output logic                  o_p0_busy,
  output logic                  o_p0_done,
  output logic                  o_p0_err,
  output logic [I2C_DATA_W-1:0] o_p0_rdata,
  input  logic                  i_p1_req,
  input  logic [I2C_ADDR_W-1:0] i_p1_addr,
  input  logic                  i_p1_rnw,
  input  logic [I2C_DATA_W-1:0] i_p1_wdata,
  output logic                  o_p1_busy,
  output logic                  o_p1_done,
  output logic                  o_p1_err,
  output logic [I2C_DATA_W-1:0] o_p1_rdata,
  output logic [I2C_ADDR_W-1:0] o_i2c_addr1,
  output logic                  o_rnw,
  output logic [I2C_DATA_W-1:0] o_wr_data,
  output logic                  o_start_stb,
  input  logic [I2C_DATA_W-1:0] i_rd_data,
  input  logic                  i_scl
);

  localparam int PH_MAX = (START_LEN > STOP_WAIT) ? START_LEN : STOP_WAIT;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [1:0]            r_pending;
  logic                  r_last;
  logic                  r_owner;
  logic                  r_err;
  logic [PH_W-1:0]       r_phase_cnt;
  i2c_op_t               r_shadow [2];
  i2c_op_t               r_gen_op;
  logic [I2C_DATA_W-1:0] r_rdata [2];

  i2c_op_t               w_in_op [2];
  logic [1:0]            w_req;
  logic                  w_winner;
  logic                  w_ph_zero;
  logic                  w_scl_done;
  logic                  w_timeout;

  assign w_in_op[0] = {i_p0_addr, i_p0_rnw, i_p0_wdata};
  assign w_in_op[1] = {i_p1_addr, i_p1_rnw, i_p1_wdata};
  assign w_req      = {i_p1_req, i_p0_req};
  assign w_ph_zero  = (r_phase_cnt == '0);

  // On a tie the port that was not served last wins.
  assign w_winner = (&r_pending) ? ~r_last : r_pending[1];

  i2c_scl_monitor #(
    .PULSES  (SCL_PULSES),
    .TIMEOUT (TIMEOUT)
  ) u_scl_mon (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_scl             (i_scl),
    .i_clear           (r_state == ST_START),
    .i_enable          (r_state == ST_BUSY),
    .o_count_reached   (w_scl_done),
    .o_timeout_reached (w_timeout)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (|r_pending) w_state_nxt = ST_START;
      ST_START: if (w_ph_zero)  w_state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (w_scl_done)     w_state_nxt = ST_DRAIN;
        else if (w_timeout) w_state_nxt = ST_DONE;
      end
      ST_DRAIN: if (w_ph_zero) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Request acceptance, grant, phase timer and completion bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pending   <= '0;
      r_last      <= 1'b1;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_phase_cnt <= '0;
      r_gen_op    <= '0;
      for (int i = 0; i < 2; i++) begin
        r_shadow[i] <= '0;
        r_rdata[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_req[i] && !r_pending[i]) begin
          r_pending[i] <= 1'b1;
          r_shadow[i]  <= w_in_op[i];
        end
      end
      case (r_state)
        ST_IDLE: begin
          if (|r_pending) begin
            r_owner     <= w_winner;
            r_gen_op    <= r_shadow[w_winner];
            r_phase_cnt <= PH_W'(START_LEN - 1);
          end
        end
        ST_START: begin
          if (!w_ph_zero) r_phase_cnt <= r_phase_cnt - 1'b1;
        end
        ST_BUSY: begin
          if (w_scl_done)     r_phase_cnt <= PH_W'(STOP_WAIT - 1);
          else if (w_timeout) r_err       <= 1'b1;
        end
        ST_DRAIN: begin
          // Latch read data so it is already valid alongside the done pulse.
          if (!w_ph_zero)          r_phase_cnt      <= r_phase_cnt - 1'b1;
          else if (r_gen_op.rnw)   r_rdata[r_owner] <= i_rd_data;
        end
        ST_DONE: begin
          r_pending[r_owner] <= 1'b0;
          r_last             <= r_owner;
          r_err              <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_p0_busy   = r_pending[0];
  assign o_p1_busy   = r_pending[1];
  assign o_p0_done   = (r_state == ST_DONE) && !r_owner;
  assign o_p1_done   = (r_state == ST_DONE) &&  r_owner;
  assign o_p0_err    = o_p0_done && r_err;
  assign o_p1_err    = o_p1_done && r_err;
  assign o_p0_rdata  = r_rdata[0];
  assign o_p1_rdata  = r_rdata[1];
  assign o_start_stb = (r_state == ST_START);
  assign o_i2c_addr1 = r_gen_op.addr;
  assign o_rnw       = r_gen_op.rnw;
  assign o_wr_data   = r_gen_op.wdata;

endmodule
